// File: rtl/mouse_receiver_pkg.sv
// Shared PS/2 definitions for the mouse receiver, transmitter and master state machine.
//   rx_state_t          : receiver state encoding
//   ERR_PARITY/ERR_STOP : bit positions inside BYTE_ERROR_CODE
//   PS2_FRAME_DATA_BITS : data bits carried by one PS/2 frame
package mouse_receiver_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DATA    = 3'd1,
      PARITY  = 3'd2,
      STOP    = 3'd3,
      DELIVER = 3'd4
   } rx_state_t;

   localparam int ERR_PARITY          = 0;
   localparam int ERR_STOP            = 1;
   localparam int PS2_FRAME_DATA_BITS = 8;

endpackage

// File: rtl/mouse_receiver_ps2_line_sync.sv
// ps2_line_sync: brings the asynchronous PS/2 clock and data lines into the
// system clock domain and flags falling edges of the PS/2 clock.
//   clk, srst   : system clock, synchronous active-high reset
//   line_clk    : raw PS/2 clock pin
//   line_data   : raw PS/2 data pin
//   clk_synced  : synchronised PS/2 clock
//   data_synced : synchronised PS/2 data
//   fall_edge   : high for one cycle when the synchronised PS/2 clock goes 1 -> 0
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic srst,
   input  logic line_clk,
   input  logic line_data,
   output logic clk_synced,
   output logic data_synced,
   output logic fall_edge
);

   logic [SYNC_STAGES-1:0] clk_pipe_reg;
   logic [SYNC_STAGES-1:0] data_pipe_reg;
   logic                   clk_prev_reg;

   // Everything presets to 1 (PS/2 idle level) so leaving reset never
   // produces a spurious falling edge.
   always_ff @(posedge clk) begin
      if (srst) begin
         clk_pipe_reg  <= '1;
         data_pipe_reg <= '1;
         clk_prev_reg  <= 1'b1;
      end else begin
         clk_pipe_reg  <= {clk_pipe_reg[SYNC_STAGES-2:0], line_clk};
         data_pipe_reg <= {data_pipe_reg[SYNC_STAGES-2:0], line_data};
         clk_prev_reg  <= clk_pipe_reg[SYNC_STAGES-1];
      end
   end

   assign clk_synced  = clk_pipe_reg[SYNC_STAGES-1];
   assign data_synced = data_pipe_reg[SYNC_STAGES-1];
   assign fall_edge   = clk_prev_reg & ~clk_pipe_reg[SYNC_STAGES-1];

endmodule

// File: rtl/mouse_receiver.sv
// mouse_receiver: PS/2 host-side byte receiver. Deframes 11-bit device-to-host
// frames (start, 8 data LSB first, odd parity, stop) and hands one byte per
// frame to the mouse master state machine.
//   CLK, RESET      : system clock, synchronous active-high reset
//   CLK_MOUSE_IN    : PS/2 clock line (asynchronous)
//   DATA_MOUSE_IN   : PS/2 data line (asynchronous)
//   READ_ENABLE     : reception permitted; low aborts any frame in progress
//   BYTE_READ       : last delivered byte
//   BYTE_ERROR_CODE : [0] parity error, [1] stop-bit error
//   BYTE_READY      : one-cycle strobe qualifying BYTE_READ/BYTE_ERROR_CODE
module mouse_receiver
   import mouse_receiver_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_MOUSE_IN,
   input  logic       DATA_MOUSE_IN,
   input  logic       READ_ENABLE,
   output logic [7:0] BYTE_READ,
   output logic [1:0] BYTE_ERROR_CODE,
   output logic       BYTE_READY
);

   localparam int             TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]     LAST_BIT     = 3'(PS2_FRAME_DATA_BITS - 1);

   logic clk_synced;
   logic data_synced;
   logic fall_edge;

   ps2_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk         (CLK),
      .srst        (RESET),
      .line_clk    (CLK_MOUSE_IN),
      .line_data   (DATA_MOUSE_IN),
      .clk_synced  (clk_synced),
      .data_synced (data_synced),
      .fall_edge   (fall_edge)
   );

   rx_state_t     state_reg,      state_next;
   logic [7:0]    shift_reg,      shift_next;
   logic [2:0]    bit_idx_reg,    bit_idx_next;
   logic [TW-1:0] timeout_reg,    timeout_next;
   logic          parity_bit_reg, parity_bit_next;
   logic [7:0]    byte_read_reg,  byte_read_next;
   logic [1:0]    err_reg,        err_next;
   logic          ready_reg,      ready_next;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg      <= IDLE;
         shift_reg      <= '0;
         bit_idx_reg    <= '0;
         timeout_reg    <= '0;
         parity_bit_reg <= 1'b0;
         byte_read_reg  <= '0;
         err_reg        <= '0;
         ready_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         shift_reg      <= shift_next;
         bit_idx_reg    <= bit_idx_next;
         timeout_reg    <= timeout_next;
         parity_bit_reg <= parity_bit_next;
         byte_read_reg  <= byte_read_next;
         err_reg        <= err_next;
         ready_reg      <= ready_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      shift_next      = shift_reg;
      bit_idx_next    = bit_idx_reg;
      timeout_next    = timeout_reg;
      parity_bit_next = parity_bit_reg;
      byte_read_next  = byte_read_reg;
      err_next        = err_reg;
      ready_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            bit_idx_next = '0;
            timeout_next = '0;
            if (READ_ENABLE && fall_edge && !data_synced) begin
               state_next = DATA;
            end
         end

         DATA, PARITY, STOP: begin
            // Enable drop beats an edge, and an edge beats the timeout.
            if (!READ_ENABLE) begin
               state_next = IDLE;
            end else if (fall_edge) begin
               timeout_next = '0;
               if (state_reg == DATA) begin
                  shift_next[bit_idx_reg] = data_synced;
                  bit_idx_next            = bit_idx_reg + 3'd1;
                  if (bit_idx_reg == LAST_BIT) begin
                     state_next = PARITY;
                  end
               end else if (state_reg == PARITY) begin
                  parity_bit_next = data_synced;
                  state_next      = STOP;
               end else begin
                  // Stop bit is judged directly so the result lands in the
                  // DELIVER cycle together with the strobe.
                  byte_read_next          = shift_reg;
                  err_next[ERR_PARITY]    = ~(^shift_reg ^ parity_bit_reg);
                  err_next[ERR_STOP]      = ~data_synced;
                  ready_next              = 1'b1;
                  state_next              = DELIVER;
               end
            end else if (timeout_reg == TIMEOUT_LAST) begin
               state_next = IDLE;
            end else begin
               timeout_next = timeout_reg + TW'(1);
            end
         end

         DELIVER: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign BYTE_READ       = byte_read_reg;
   assign BYTE_ERROR_CODE = err_reg;
   assign BYTE_READY      = ready_reg;

endmodule

// File: tb/tb_mouse_receiver.sv
// Self-checking bench for mouse_receiver: table of complete frames plus
// hand-written timeout, enable-abort and reset-mid-frame sequences.
module tb_mouse_receiver;

   localparam int HALF = 20;  // PS/2 half period in CLK cycles

   logic       clk = 1'b0;
   logic       srst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       read_enable;
   logic [7:0] byte_read;
   logic [1:0] err_code;
   logic       byte_ready;

   always #5 clk = ~clk;

   mouse_receiver #(
      .TIMEOUT_CYCLES (500),
      .SYNC_STAGES    (2)
   ) dut (
      .CLK             (clk),
      .RESET           (srst),
      .CLK_MOUSE_IN    (ps2_clk),
      .DATA_MOUSE_IN   (ps2_data),
      .READ_ENABLE     (read_enable),
      .BYTE_READ       (byte_read),
      .BYTE_ERROR_CODE (err_code),
      .BYTE_READY      (byte_ready)
   );

   // Strobe monitor
   int   strobe_total = 0;
   int   consec_bad   = 0;
   logic prev_ready   = 1'b0;

   always @(negedge clk) begin
      if (byte_ready) begin
         strobe_total <= strobe_total + 1;
         if (prev_ready) consec_bad <= consec_bad + 1;
      end
      prev_ready <= byte_ready;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Sends edges [first, first+count) of frame {stop, parity, data, start}.
   task automatic ps2_frame(input logic [7:0] d, input logic p, input logic s,
                            input int first, input int count);
      logic [10:0] bits;
      bits = {s, p, d, 1'b0};
      for (int i = first; i < first + count; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(posedge clk);
      ps2_data = 1'b1;
   endtask

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       s;
      logic       re;
      logic [7:0] exp_strobes;
      logic [7:0] exp_byte;
      logic [1:0] exp_code;
   } vec_t;

   vec_t vecs [7];
   int   snap;

   initial begin
      vecs[0] = '{8'hFA, 1'b1, 1'b1, 1'b1, 8'd1, 8'hFA, 2'b00};
      vecs[1] = '{8'hAA, 1'b1, 1'b1, 1'b1, 8'd1, 8'hAA, 2'b00};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'd1, 8'h00, 2'b00};
      vecs[3] = '{8'hFA, 1'b0, 1'b1, 1'b1, 8'd1, 8'hFA, 2'b01};
      vecs[4] = '{8'h08, 1'b0, 1'b0, 1'b1, 8'd1, 8'h08, 2'b10};
      vecs[5] = '{8'h01, 1'b1, 1'b0, 1'b1, 8'd1, 8'h01, 2'b11};
      vecs[6] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'd0, 8'h01, 2'b11};

      srst        = 1'b1;
      ps2_clk     = 1'b1;
      ps2_data    = 1'b1;
      read_enable = 1'b0;
      repeat (3) @(posedge clk);
      srst = 1'b0;
      @(negedge clk);
      check("reset_byte",  32'(byte_read),  32'h00);
      check("reset_code",  32'(err_code),   32'h0);
      check("reset_ready", 32'(byte_ready), 32'h0);

      for (int i = 0; i < 7; i++) begin
         read_enable = vecs[i].re;
         snap = strobe_total;
         ps2_frame(vecs[i].d, vecs[i].p, vecs[i].s, 0, 11);
         repeat (10) @(posedge clk);
         @(negedge clk);
         $display("vec %0d: sent=%02h re=%b strobes=%0d byte=%02h code=%b",
                  i, vecs[i].d, vecs[i].re, strobe_total - snap, byte_read, err_code);
         check($sformatf("vec%0d_strobes", i), 32'(strobe_total - snap), 32'(vecs[i].exp_strobes));
         check($sformatf("vec%0d_byte", i),    32'(byte_read),            32'(vecs[i].exp_byte));
         check($sformatf("vec%0d_code", i),    32'(err_code),             32'(vecs[i].exp_code));
      end

      // Timeout: abandoned partial frame must not corrupt the next one.
      read_enable = 1'b1;
      snap = strobe_total;
      ps2_frame(8'h3C, 1'b1, 1'b1, 0, 6);
      repeat (600) @(posedge clk);
      ps2_frame(8'h3C, 1'b1, 1'b1, 0, 11);
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("timeout seq: strobes=%0d byte=%02h code=%b", strobe_total - snap, byte_read, err_code);
      check("timeout_strobes", 32'(strobe_total - snap), 32'd1);
      check("timeout_byte",    32'(byte_read),           32'h3C);
      check("timeout_code",    32'(err_code),            32'h0);

      // Enable drop after the 4th data bit; rest of the frame arrives disabled.
      snap = strobe_total;
      ps2_frame(8'h55, 1'b1, 1'b1, 0, 5);
      read_enable = 1'b0;
      repeat (5) @(posedge clk);
      ps2_frame(8'h55, 1'b1, 1'b1, 5, 6);
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("enable abort: strobes=%0d byte=%02h", strobe_total - snap, byte_read);
      check("abort_strobes", 32'(strobe_total - snap), 32'd0);
      check("abort_byte",    32'(byte_read),           32'h3C);

      // Reset during bit 6, then a clean 0x11 frame.
      read_enable = 1'b1;
      snap = strobe_total;
      ps2_frame(8'h11, 1'b1, 1'b1, 0, 7);
      ps2_data = 1'b0;
      repeat (5) @(posedge clk);
      srst = 1'b1;
      @(posedge clk);
      srst = 1'b0;
      @(negedge clk);
      $display("reset mid-frame: strobes=%0d byte=%02h code=%b ready=%b",
               strobe_total - snap, byte_read, err_code, byte_ready);
      check("midrst_byte",  32'(byte_read),  32'h00);
      check("midrst_code",  32'(err_code),   32'h0);
      check("midrst_ready", 32'(byte_ready), 32'h0);
      ps2_data = 1'b1;
      repeat (10) @(posedge clk);
      ps2_frame(8'h11, 1'b1, 1'b1, 0, 11);
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("after reset: strobes=%0d byte=%02h code=%b", strobe_total - snap, byte_read, err_code);
      check("post_strobes", 32'(strobe_total - snap), 32'd1);
      check("post_byte",    32'(byte_read),           32'h11);
      check("post_code",    32'(err_code),            32'h0);

      check("no_consecutive_ready", 32'(consec_bad), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
